rv_program_loader: RTL

Serial boot loader for the single-cycle RISC-V core. It consumes a framed byte stream from the UART receiver and writes it into instruction memory through the core's programming port. While loading it holds the core halted, verifies a checksum, then releases the core through a reset pulse. It sits between the UART RX block and the core top's `hlt` / `pgm_mode` / `pgm_addr` / `pgm_data` / `inst_mem_we` inputs.

---
 rtl/rv_loader_pkg.sv | 25 ++
 rtl/rv_loader_timeout.sv | 38 +++
 rtl/rv_program_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_loader_pkg
// Brief    : Shared constants and state encoding for the serial program loader.
// Revision : 1.0 - initial release
// ============================================================================
package rv_loader_pkg;

    localparam int unsigned C_LEN_W     = 16;
    localparam int unsigned C_ADDR_W    = 10;
    localparam logic [7:0]  C_SYNC_BYTE = 8'hA5;

    localparam int unsigned C_ST_W = 3;
    typedef logic [C_ST_W-1:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_LEN_LO     = 3'd1;
    localparam state_t S_LEN_HI     = 3'd2;
    localparam state_t S_DATA       = 3'd3;
    localparam state_t S_CSUM       = 3'd4;
    localparam state_t S_RESET_CORE = 3'd5;
    localparam state_t S_ERROR      = 3'd6;

endpackage
`default_nettype wire

// File: rtl/rv_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module   : rv_loader_timeout
// Brief    : Inter-byte idle counter; flags expiry after TIMEOUT_CYCLES quiet cycles.
// Revision : 1.0 - initial release
// ============================================================================
module rv_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_reload,
    output logic o_expired
);

    localparam int unsigned C_CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned C_LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_LIMIT_I[C_CNT_W-1:0];
    localparam logic [C_CNT_W-1:0] C_ONE   = {{(C_CNT_W-1){1'b0}}, 1'b1};

    logic [C_CNT_W-1:0] r_count;

    // Expiry is seen in the TIMEOUT_CYCLES-th quiet cycle after the last byte.
    assign o_expired = (r_count == C_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_enable || i_reload) begin
            r_count <= '0;
        end else if (!o_expired) begin
            r_count <= r_count + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : rv_program_loader
// Brief    : Framed UART boot loader writing instruction memory, then releasing the core.
// Revision : 1.0 - initial release
// ============================================================================
module rv_program_loader
    import rv_loader_pkg::*;
#(
    parameter int unsigned IMEM_BYTES     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned RST_CYCLES     = 16,
    parameter logic [7:0]  SYNC_BYTE      = C_SYNC_BYTE
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                rx_err,
    output logic                hlt,
    output logic                pgm_mode,
    output logic [C_ADDR_W-1:0] pgm_addr,
    output logic [7:0]          pgm_data,
    output logic                inst_mem_we,
    output logic                core_rst_n,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [C_LEN_W:0] C_MAX_LEN = IMEM_BYTES[C_LEN_W:0];

    localparam int unsigned C_RST_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int unsigned C_RST_LAST_I = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;
    localparam logic [C_RST_W-1:0] C_RST_LAST = C_RST_LAST_I[C_RST_W-1:0];
    localparam logic [C_RST_W-1:0] C_RST_ONE  = {{(C_RST_W-1){1'b0}}, 1'b1};
    localparam logic [C_ADDR_W-1:0] C_ADDR_ONE = {{(C_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [C_LEN_W-1:0]  C_LEN_ONE  = {{(C_LEN_W-1){1'b0}}, 1'b1};

    state_t               r_state, w_state_next;
    logic [C_LEN_W-1:0]   r_len, w_len_next;
    logic [C_LEN_W-1:0]   r_cnt, w_cnt_next;
    logic [7:0]           r_sum, w_sum_next;
    logic [C_ADDR_W-1:0]  r_addr, w_addr_next;
    logic [7:0]           r_data, w_data_next;
    logic                 r_we, w_we_next;
    logic [C_RST_W-1:0]   r_rst_cnt, w_rst_cnt_next;
    logic                 r_hlt, r_core_rst_n, r_busy, r_done, r_err;
    logic                 w_hlt_next;
    logic                 w_in_frame;
    logic                 w_timeout;
    logic                 w_is_sync;
    logic [C_LEN_W-1:0]   w_len_full;
    logic [C_LEN_W-1:0]   w_cnt_inc;

    assign w_in_frame = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_is_sync  = rx_valid && (rx_data == SYNC_BYTE);
    assign w_len_full = {rx_data, r_len[7:0]};
    assign w_cnt_inc  = r_cnt + C_LEN_ONE;

    rv_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (sys_clk),
        .rst_n     (sys_rst),
        .i_enable  (w_in_frame),
        .i_reload  (rx_valid),
        .o_expired (w_timeout)
    );

    always_comb begin
        w_state_next   = r_state;
        w_len_next     = r_len;
        w_cnt_next     = r_cnt;
        w_sum_next     = r_sum;
        w_addr_next    = r_addr;
        w_data_next    = r_data;
        w_we_next      = 1'b0;
        w_rst_cnt_next = r_rst_cnt;

        // Address advances the cycle after each write strobe.
        if (r_we) begin
            w_addr_next = r_addr + C_ADDR_ONE;
        end

        case (r_state)
            S_IDLE: begin
                if (w_is_sync) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    w_len_next[7:0] = rx_data;
                    w_state_next    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    w_len_next  = w_len_full;
                    w_cnt_next  = '0;
                    w_sum_next  = '0;
                    w_addr_next = '0;
                    if ({1'b0, w_len_full} > C_MAX_LEN) begin
                        w_state_next = S_ERROR;
                    end else if (w_len_full == '0) begin
                        w_state_next = S_CSUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // SYNC_BYTE here is plain payload.
                if (rx_valid) begin
                    w_data_next = rx_data;
                    w_we_next   = 1'b1;
                    w_sum_next  = r_sum + rx_data;
                    w_cnt_next  = w_cnt_inc;
                    if (w_cnt_inc == r_len) w_state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == r_sum) begin
                        w_state_next   = S_RESET_CORE;
                        w_rst_cnt_next = '0;
                    end else begin
                        w_state_next = S_ERROR;
                    end
                end
            end
            S_RESET_CORE: begin
                if (r_rst_cnt == C_RST_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_rst_cnt_next = r_rst_cnt + C_RST_ONE;
                end
            end
            S_ERROR: begin
                if (w_is_sync) w_state_next = S_LEN_LO;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A line error discards the byte; an arriving byte beats a timeout.
        if ((r_state != S_IDLE) && rx_err) begin
            w_state_next = S_ERROR;
            w_we_next    = 1'b0;
        end else if (w_in_frame && w_timeout && !rx_valid) begin
            w_state_next = S_ERROR;
        end

        w_hlt_next = (w_state_next != S_IDLE) &&
                     !((w_state_next == S_RESET_CORE) && (w_rst_cnt_next == C_RST_LAST));
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_rst_cnt    <= '0;
            r_hlt        <= 1'b0;
            r_core_rst_n <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_len        <= w_len_next;
            r_cnt        <= w_cnt_next;
            r_sum        <= w_sum_next;
            r_addr       <= w_addr_next;
            r_data       <= w_data_next;
            r_we         <= w_we_next;
            r_rst_cnt    <= w_rst_cnt_next;
            r_hlt        <= w_hlt_next;
            r_core_rst_n <= (w_state_next != S_RESET_CORE);
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= (r_state == S_RESET_CORE) && (w_state_next == S_IDLE);
            r_err        <= (w_state_next == S_ERROR);
        end
    end

    assign hlt         = r_hlt;
    assign pgm_mode    = r_hlt;
    assign pgm_addr    = r_addr;
    assign pgm_data    = r_data;
    assign inst_mem_we = r_we;
    assign core_rst_n  = r_core_rst_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire
